// File: rtl/current_trip_pkg.sv
// Shared types, constants and sizing helpers for the overcurrent trip sequencer.
package current_trip_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLDOFF = 2'd2,
    LATCH   = 2'd3
  } state_t;

  localparam int TRIP_CNT_W = 8;
  localparam logic [TRIP_CNT_W-1:0] TRIP_CNT_MAX = {TRIP_CNT_W{1'b1}};

  // Bits needed to hold every value from 0 up to max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Trip counter increment that sticks at full scale instead of wrapping.
  function automatic logic [TRIP_CNT_W-1:0] sat_inc(input logic [TRIP_CNT_W-1:0] val);
    return (val == TRIP_CNT_MAX) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/trip_timer.sv
// Loadable down-counter. Loading N gives done high N cycles later; done stays
// high once the count has drained to zero until the next load.
module trip_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/current_trip_ctrl.sv
// Overcurrent protection sequencer: debounces the comparator flag, drops the
// load switch on a qualified trip, waits a hold-off, retries a bounded number
// of times and then latches off until software clears it.
// Optional inrush blanking window after each RUN entry: define CURRENT_TRIP_BLANK_EN.
module current_trip_ctrl
  import current_trip_pkg::*;
#(
  parameter int  DEBOUNCE_CYC = 16,
  parameter int  HOLDOFF_CYC  = 1000,
  parameter int  MAX_RETRY    = 3,
  parameter int  BLANK_CYC    = 64,
  localparam int RETRY_W      = cnt_width(MAX_RETRY)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  over_thld,
  input  logic                  enable,
  input  logic                  clear,
  output logic                  power_en,
  output logic                  tripped,
  output logic                  latched,
  output logic [TRIP_CNT_W-1:0] trip_count,
  output logic [RETRY_W-1:0]    retry_cnt
`ifdef CURRENT_TRIP_BLANK_EN
  ,
  output logic                  blanking
`endif
);

  // One timer width is sized for the longer of the two windows so the hold-off
  // and blanking timers can share the same geometry.
  localparam int DEB_W = cnt_width(DEBOUNCE_CYC);
  localparam int TMR_W = cnt_width(max_int(HOLDOFF_CYC, BLANK_CYC));

  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0]   HOLD_LOAD = TMR_W'(HOLDOFF_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t                  state;
  state_t                  state_next;
  logic [DEB_W-1:0]        deb_cnt;
  logic [DEB_W-1:0]        deb_next;
  logic [RETRY_W-1:0]      retry_next;
  logic [TRIP_CNT_W-1:0]   trip_next;
  logic                    trip_hit;
  logic                    hold_load;
  logic                    hold_done;
  logic                    blank_hold;

  // Hold-off timer is armed on the trip edge; it reads done on the edge that
  // ends the last hold-off cycle.
  trip_timer #(
    .WIDTH(TMR_W)
  ) u_hold_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (hold_load),
    .load_val(HOLD_LOAD),
    .done    (hold_done)
  );

`ifdef CURRENT_TRIP_BLANK_EN
  localparam logic [TMR_W-1:0] BLANK_LOAD = TMR_W'(BLANK_CYC - 1);

  logic run_entry;
  logic blank_done;
  logic blank_act;
  logic blank_act_next;

  assign run_entry = (state_next == RUN) && (state != RUN);

  trip_timer #(
    .WIDTH(TMR_W)
  ) u_blank_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (run_entry),
    .load_val(BLANK_LOAD),
    .done    (blank_done)
  );

  // Window opens on every RUN entry, closes when the timer drains or RUN is left.
  always_comb begin
    blank_act_next = 1'b0;
    if (run_entry) begin
      blank_act_next = 1'b1;
    end else if ((state == RUN) && (state_next == RUN) && blank_act && !blank_done) begin
      blank_act_next = 1'b1;
    end
  end

  // Register the window flag so the blanking output is glitch-free.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blank_act <= 1'b0;
    end else begin
      blank_act <= blank_act_next;
    end
  end

  assign blank_hold = blank_act;
  assign blanking   = blank_act;
`else
  assign blank_hold = 1'b0;
`endif

  // Next-state, debounce and counter updates; clear always zeroes the trip
  // count, and only leaves a state when that state is LATCH.
  always_comb begin
    state_next = state;
    deb_next   = '0;
    retry_next = retry_cnt;
    trip_next  = trip_count;
    trip_hit   = 1'b0;
    hold_load  = 1'b0;

    if (clear) begin
      trip_next = '0;
    end

    unique case (state)
      IDLE: begin
        if (enable) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (!blank_hold && over_thld) begin
          if (deb_cnt == DEB_LAST) begin
            trip_hit = 1'b1;
          end else begin
            deb_next = deb_cnt + 1'b1;
          end
        end
        if (trip_hit && !clear) begin
          trip_next = sat_inc(trip_count);
        end
        if (!enable) begin
          state_next = IDLE;
          retry_next = '0;
        end else if (trip_hit) begin
          state_next = HOLDOFF;
          hold_load  = 1'b1;
        end
      end

      HOLDOFF: begin
        if (!enable) begin
          state_next = IDLE;
          retry_next = '0;
        end else if (hold_done) begin
          if (retry_cnt < RETRY_MAX) begin
            state_next = RUN;
            retry_next = retry_cnt + 1'b1;
          end else begin
            state_next = LATCH;
          end
        end
      end

      LATCH: begin
        if (clear) begin
          state_next = IDLE;
          retry_next = '0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      deb_cnt    <= '0;
      retry_cnt  <= '0;
      trip_count <= '0;
    end else begin
      state      <= state_next;
      deb_cnt    <= deb_next;
      retry_cnt  <= retry_next;
      trip_count <= trip_next;
    end
  end

  assign power_en = (state == RUN);
  assign tripped  = (state == HOLDOFF) || (state == LATCH);
  assign latched  = (state == LATCH);

endmodule

// File: tb/tb_current_trip_ctrl.sv
// Self-checking bench for current_trip_ctrl. Expected outputs are queued as
// each vector is driven and popped when the following clock edge has settled.
// Build with CURRENT_TRIP_BLANK_EN defined to also cover the blanking window.
module tb_current_trip_ctrl;

  localparam int DEB   = 4;
  localparam int HOLD  = 10;
  localparam int MAXR  = 2;
  localparam int BLANK = 5;
  localparam int RW    = $clog2(MAXR + 1);

`ifdef CURRENT_TRIP_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
  localparam int PAD      = BLANK;
`else
  localparam bit BLANK_ON = 1'b0;
  localparam int PAD      = 0;
`endif

  typedef struct packed {
    logic       rst;
    logic       ot;
    logic       en;
    logic       clr;
    logic       pe;
    logic       tr;
    logic       la;
    logic [7:0] tc;
    logic [7:0] rc;
    logic       bl;
  } vec_t;

  logic          clk;
  logic          reset_n;
  logic          over_thld;
  logic          enable;
  logic          clear;
  logic          power_en;
  logic          tripped;
  logic          latched;
  logic [7:0]    trip_count;
  logic [RW-1:0] retry_cnt;
  logic          act_bl;

  int   total;
  int   bad;
  vec_t exp_q[$];
  vec_t tbl[$];

`ifdef CURRENT_TRIP_BLANK_EN
  logic blanking;
  assign act_bl = blanking;
`else
  assign act_bl = 1'b0;
`endif

  current_trip_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .HOLDOFF_CYC (HOLD),
    .MAX_RETRY   (MAXR),
    .BLANK_CYC   (BLANK)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .over_thld (over_thld),
    .enable    (enable),
    .clear     (clear),
    .power_en  (power_en),
    .tripped   (tripped),
    .latched   (latched),
    .trip_count(trip_count),
    .retry_cnt (retry_cnt)
`ifdef CURRENT_TRIP_BLANK_EN
    ,
    .blanking  (blanking)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input bit rst, input bit ot, input bit en, input bit clr,
                              input bit pe, input bit tr, input bit la,
                              input int tc, input int rc, input bit bl);
    vec_t v;
    v.rst = rst; v.ot = ot; v.en = en; v.clr = clr;
    v.pe  = pe;  v.tr = tr; v.la = la;
    v.tc  = 8'(tc);
    v.rc  = 8'(rc);
    v.bl  = bl;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset_n   = v.rst;
    over_thld = v.ot;
    enable    = v.en;
    clear     = v.clr;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t        e;
    logic [19:0] act;
    logic [19:0] want;
    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty step=%0d", total);
      return;
    end
    e    = exp_q.pop_front();
    act  = {power_en, tripped, latched, trip_count, 8'(retry_cnt), act_bl};
    want = {e.pe, e.tr, e.la, e.tc, e.rc, e.bl};
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL outputs step=%0d got pe=%0b tr=%0b la=%0b tc=%0d rc=%0d bl=%0b want pe=%0b tr=%0b la=%0b tc=%0d rc=%0d bl=%0b",
               total, power_en, tripped, latched, trip_count, retry_cnt, act_bl,
               e.pe, e.tr, e.la, e.tc, e.rc, e.bl);
    end
  endtask

  task automatic stepVec(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  task automatic add(input bit rst, input bit ot, input bit en, input bit clr,
                     input bit pe, input bit tr, input bit la,
                     input int tc, input int rc, input bit bl);
    tbl.push_back(mk(rst, ot, en, clr, pe, tr, la, tc, rc, bl));
  endtask

  // Cycles in RUN after entry during which debounce is frozen (none without blanking).
  task automatic addPad(input bit ot, input int tc, input int rc);
    for (int i = 0; i < PAD; i++) add(1, ot, 1, 0, 1, 0, 0, tc, rc, (i < PAD - 1));
  endtask

  task automatic doPad(input bit ot, input int tc, input int rc);
    for (int i = 0; i < PAD; i++) stepVec(mk(1, ot, 1, 0, 1, 0, 0, tc, rc, (i < PAD - 1)));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog step=%0d got timeout want completion", total);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int prev;
    int now;
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    over_thld = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;

    // Reset, power-up, and a short burst below the debounce count.
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 0, 0, BLANK_ON);
    addPad(0, 0, 0);
    for (int i = 0; i < DEB - 1; i++) add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);

    // Stuck-high: every retry trips again until the retry budget runs out.
    for (int t = 0; t <= MAXR; t++) begin
      for (int i = 0; i < DEB - 1; i++) add(1, 1, 1, 0, 1, 0, 0, t, t, 0);
      add(1, 1, 1, 0, 0, 1, 0, t + 1, t, 0);
      for (int i = 0; i < HOLD - 1; i++) add(1, 1, 1, 0, 0, 1, 0, t + 1, t, 0);
      if (t < MAXR) begin
        add(1, 1, 1, 0, 1, 0, 0, t + 1, t + 1, BLANK_ON);
        addPad(1, t + 1, t + 1);
      end else begin
        add(1, 1, 1, 0, 0, 1, 1, t + 1, t, 0);
      end
    end

    // LATCH ignores enable; clear returns to IDLE with both counters zeroed.
    add(1, 1, 0, 0, 0, 1, 1, MAXR + 1, MAXR, 0);
    add(1, 1, 1, 0, 0, 1, 1, MAXR + 1, MAXR, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 0, 0, BLANK_ON);
    addPad(0, 0, 0);

    // Trip, retry, trip again, then drop enable in the middle of hold-off.
    for (int i = 0; i < DEB - 1; i++) add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < HOLD - 1; i++) add(1, 0, 1, 0, 0, 1, 0, 1, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 1, 1, BLANK_ON);
    addPad(0, 1, 1);
    for (int i = 0; i < DEB - 1; i++) add(1, 1, 1, 0, 1, 0, 0, 1, 1, 0);
    add(1, 1, 1, 0, 0, 1, 0, 2, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, 1, 0, 2, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 2, 0, 0);

    // Clear in IDLE and in RUN only zeroes trip_count; retries are not refunded.
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 0, 0, BLANK_ON);
    addPad(0, 0, 0);
    for (int i = 0; i < DEB - 1; i++) add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < HOLD - 1; i++) add(1, 0, 1, 0, 0, 1, 0, 1, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 1, 1, BLANK_ON);
    addPad(0, 1, 1);
    add(1, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < DEB - 1; i++) add(1, 1, 1, 0, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 2; i++) add(1, 0, 1, 0, 0, 1, 0, 1, 1, 0);
    // clear together with enable low in HOLDOFF applies both.
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) stepVec(tbl[i]);

    // Reset asserted mid-RUN after a trip and a retry returns everything to zero.
    stepVec(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, BLANK_ON));
    doPad(0, 0, 0);
    for (int i = 0; i < DEB - 1; i++) stepVec(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    stepVec(mk(1, 1, 1, 0, 0, 1, 0, 1, 0, 0));
    for (int i = 0; i < HOLD - 1; i++) stepVec(mk(1, 0, 1, 0, 0, 1, 0, 1, 0, 0));
    stepVec(mk(1, 0, 1, 0, 1, 0, 0, 1, 1, BLANK_ON));
    doPad(0, 1, 1);
    stepVec(mk(1, 1, 1, 0, 1, 0, 0, 1, 1, 0));
    stepVec(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    stepVec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // enable drops on the trip edge: IDLE wins but the trip is counted, and
    // repeating it past full scale shows trip_count saturating at 255.
    for (int k = 1; k <= 257; k++) begin
      prev = (k - 1 > 255) ? 255 : k - 1;
      now  = (k > 255) ? 255 : k;
      stepVec(mk(1, 0, 1, 0, 1, 0, 0, prev, 0, BLANK_ON));
      doPad(0, prev, 0);
      for (int i = 0; i < DEB - 1; i++) stepVec(mk(1, 1, 1, 0, 1, 0, 0, prev, 0, 0));
      stepVec(mk(1, 1, 0, 0, 0, 0, 0, now, 0, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
